// File: rtl/quad_decoder_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
//   Shared definitions for the quadrature decoder: resolution mode codes,
//   the {prev, curr} transition codes of the Gray sequence, and a helper that
//   classifies one filtered-state transition.
//   State bit order everywhere is {A, B}.
// -----------------------------------------------------------------------------
package quad_pkg;

  // Resolution select codes; code 3 is reserved and decodes as x4.
  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // Up direction: 00 -> 10 -> 11 -> 01 -> 00 (A leads B). Codes are {prev, curr}.
  localparam logic [3:0] UP_00_10 = 4'b00_10;
  localparam logic [3:0] UP_10_11 = 4'b10_11;
  localparam logic [3:0] UP_11_01 = 4'b11_01;
  localparam logic [3:0] UP_01_00 = 4'b01_00;

  // Down direction is the same ring walked backwards.
  localparam logic [3:0] DN_00_01 = 4'b00_01;
  localparam logic [3:0] DN_01_11 = 4'b01_11;
  localparam logic [3:0] DN_11_10 = 4'b11_10;
  localparam logic [3:0] DN_10_00 = 4'b10_00;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_UP      = 2'd1,
    TR_DOWN    = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_e;

  // Classify a transition between two filtered {A,B} states.
  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] curr);
    trans_e t;
    t = TR_NONE;
    case ({prev, curr})
      UP_00_10, UP_10_11, UP_11_01, UP_01_00: t = TR_UP;
      DN_00_01, DN_01_11, DN_11_10, DN_10_00: t = TR_DOWN;
      default: begin
        // Both bits flipping at once cannot come from a real encoder.
        if ((prev ^ curr) == 2'b11) t = TR_ILLEGAL;
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// -----------------------------------------------------------------------------
// quad_decoder_if
//   Bundles the encoder pins, control inputs and decoded outputs of
//   quad_decoder. The master side (user logic / pins) drives a, b, mode,
//   clear, load, load_value; the slave side (the decoder) drives value, dir,
//   step, err, err_sticky.
// -----------------------------------------------------------------------------
interface quad_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a;
  logic             b;
  logic [1:0]       mode;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] value;
  logic             dir;
  logic             step;
  logic             err;
  logic             err_sticky;

  modport master (
    output a, b, mode, clear, load, load_value,
    input  value, dir, step, err, err_sticky
  );

  modport slave (
    input  a, b, mode, clear, load, load_value,
    output value, dir, step, err, err_sticky
  );
endinterface

// File: rtl/quad_decoder_input_filter.sv
// -----------------------------------------------------------------------------
// quad_input_filter
//   One encoder channel: SYNC_STAGES-deep synchroniser followed by a glitch
//   filter. The filtered level only moves once the synced level has differed
//   from it for FILTER_LEN counted cycles; FILTER_LEN = 0 leaves just a
//   single register stage so the overall latency formula stays uniform.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   raw       in   asynchronous encoder pin
//   filtered  out  synchronised, de-glitched level
// -----------------------------------------------------------------------------
module quad_input_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filtered
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          filt_q <= 1'b0;
        end else begin
          filt_q <= synced;
        end
      end
    end else begin : g_filter
      localparam int unsigned    CNT_W   = $clog2(FILTER_LEN + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             filt_d;

      // The counter holds how many cycles the synced level has disagreed.
      // Once it has reached FILTER_LEN and the disagreement persists for one
      // more cycle, the filtered level follows; any agreement restarts it.
      always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (synced == filt_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          filt_d = synced;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end
    end
  endgenerate

  assign filtered = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//   Quadrature decoder: per-channel synchroniser + glitch filter, then a
//   transition decoder that counts x1/x2/x4 steps into a WIDTH-bit position
//   with wrap or saturate arithmetic, load/clear, direction and illegal-
//   transition reporting. All outputs are registered.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (release synchronously)
//   bus      slave modport of quad_decoder_if:
//              a, b         raw encoder channels
//              mode         0 = x1, 1 = x2, 2/3 = x4
//              clear        synchronous clear of value and err_sticky
//              load         synchronous load of load_value
//              value        position count
//              dir          direction of last counted step (1 = up)
//              step         one-cycle pulse per counted step
//              err          one-cycle pulse per illegal transition
//              err_sticky   latched err, cleared by clear or reset
// -----------------------------------------------------------------------------
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILTER_LEN  = 4,
  parameter bit               SATURATE    = 1'b0
) (
  input logic          clk,
  input logic          reset_n,
  quad_decoder_if.slave bus
);

  localparam logic [WIDTH-1:0] VALUE_MAX = '1;

  logic [1:0] raw_ab;
  logic [1:0] filt_ab;

  assign raw_ab = {bus.a, bus.b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
      ) u_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (raw_ab[gi]),
        .filtered(filt_ab[gi])
      );
    end
  endgenerate

  logic [1:0]       prev_q;
  logic [WIDTH-1:0] value_q, value_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;

  trans_e     trans;
  logic [3:0] code;
  logic       legal_step;
  logic       counted;

  // One counted step applied to the position, honouring the SATURATE choice.
  function automatic logic [WIDTH-1:0] apply_step(input logic [WIDTH-1:0] v, input logic up);
    logic [WIDTH-1:0] r;
    if (SATURATE) begin
      if (up) r = (v >= VALUE_MAX - STEP) ? VALUE_MAX : v + STEP;
      else    r = (v < STEP) ? '0 : v - STEP;
    end else begin
      r = up ? v + STEP : v - STEP;
    end
    return r;
  endfunction

  always_comb begin
    trans      = classify(prev_q, filt_ab);
    code       = {prev_q, filt_ab};
    legal_step = (trans == TR_UP) || (trans == TR_DOWN);
    counted    = 1'b0;
    case (bus.mode)
      // x1 counts only the 00<->10 edge of each cycle.
      MODE_X1: counted = (code == UP_00_10) || (code == DN_10_00);
      // x2 counts the edges where A moves.
      MODE_X2: counted = legal_step && (prev_q[1] != filt_ab[1]);
      // x4 and the reserved code count every legal transition.
      default: counted = legal_step;
    endcase

    value_d = value_q;
    if (bus.clear) begin
      value_d = '0;
    end else if (bus.load) begin
      value_d = bus.load_value;
    end else if (counted) begin
      value_d = apply_step(value_q, trans == TR_UP);
    end

    // step/dir report the decoded step even when clear/load override value.
    step_d       = counted;
    dir_d        = counted ? (trans == TR_UP) : dir_q;
    err_d        = (trans == TR_ILLEGAL);
    err_sticky_d = bus.clear ? 1'b0 : (err_sticky_q | err_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= 2'b00;
      value_q      <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      prev_q       <= filt_ab;
      value_q      <= value_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.value      = value_q;
  assign bus.dir        = dir_q;
  assign bus.step       = step_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
//   Drives one wrapping and one saturating decoder with identical stimulus.
//   A reference model predicts outputs from Gray-ring positions and plain
//   integer arithmetic; each clean pin change is scheduled to reach the
//   decoder SYNC_STAGES+FILTER_LEN+1 edges after its first sampling edge.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int WIDTH  = 8;
  localparam int STEPV  = 1;
  localparam int SYNC   = 2;
  localparam int FILT   = 4;
  localparam int LAT    = SYNC + FILT + 1;
  localparam int MODV   = 1 << WIDTH;
  localparam int MAXV   = MODV - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic tb_a, tb_b, tb_clear, tb_load;
  logic [1:0] tb_mode;
  logic [WIDTH-1:0] tb_lv;

  always #5 clk = ~clk;

  quad_decoder_if #(.WIDTH(WIDTH)) if_w ();
  quad_decoder_if #(.WIDTH(WIDTH)) if_s ();

  assign if_w.a = tb_a;       assign if_s.a = tb_a;
  assign if_w.b = tb_b;       assign if_s.b = tb_b;
  assign if_w.mode = tb_mode; assign if_s.mode = tb_mode;
  assign if_w.clear = tb_clear; assign if_s.clear = tb_clear;
  assign if_w.load = tb_load; assign if_s.load = tb_load;
  assign if_w.load_value = tb_lv; assign if_s.load_value = tb_lv;

  quad_decoder #(.WIDTH(WIDTH), .STEP(8'(STEPV)), .SYNC_STAGES(SYNC),
                 .FILTER_LEN(FILT), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .reset_n(rst_n), .bus(if_w));

  quad_decoder #(.WIDTH(WIDTH), .STEP(8'(STEPV)), .SYNC_STAGES(SYNC),
                 .FILTER_LEN(FILT), .SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .reset_n(rst_n), .bus(if_s));

  typedef struct {
    int         due;
    logic [1:0] ab;
  } ev_t;

  ev_t evq[$];

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;
  int step_pulses = 0;
  int err_pulses = 0;
  int last_step_edge = -1;

  // model state
  int   m_val_w = 0, m_val_s = 0;
  bit   m_dir = 0, m_step = 0, m_err = 0, m_sticky = 0;
  logic [1:0] m_prev = 2'b00;

  logic [1:0] up_seq [4];
  logic [1:0] dn_seq [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Position of a {A,B} state on the up ring 00,10,11,01.
  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_edge();
    ev_t e;
    bit counted, up, illegal;
    int po, pn, d;
    counted = 0; up = 0; illegal = 0;
    if (evq.size() != 0 && evq[0].due == edge_n) begin
      e  = evq.pop_front();
      po = gray_pos(m_prev);
      pn = gray_pos(e.ab);
      d  = (pn - po + 4) % 4;
      if (d == 2) begin
        illegal = 1;
      end else if (d != 0) begin
        up = (d == 1);
        case (tb_mode)
          2'd0:    counted = (po + pn == 1);
          2'd1:    counted = (m_prev[1] != e.ab[1]);
          default: counted = 1;
        endcase
      end
      m_prev = e.ab;
    end
    m_step = counted;
    m_err  = illegal;
    if (counted) m_dir = up;
    if (tb_clear) begin
      m_val_w = 0; m_val_s = 0;
    end else if (tb_load) begin
      m_val_w = int'(tb_lv); m_val_s = int'(tb_lv);
    end else if (counted) begin
      if (up) begin
        m_val_w = (m_val_w + STEPV) % MODV;
        m_val_s = (m_val_s + STEPV > MAXV) ? MAXV : m_val_s + STEPV;
      end else begin
        m_val_w = (m_val_w - STEPV + MODV) % MODV;
        m_val_s = (m_val_s - STEPV < 0) ? 0 : m_val_s - STEPV;
      end
    end
    m_sticky = tb_clear ? 0 : (m_sticky | illegal);
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        m_val_w = 0; m_val_s = 0; m_dir = 0; m_step = 0; m_err = 0;
        m_sticky = 0; m_prev = 2'b00;
        evq.delete();
      end else begin
        model_edge();
      end
      #1;
      if (if_w.step) begin
        step_pulses++;
        last_step_edge = edge_n;
      end
      if (if_w.err) err_pulses++;
      chk("cyc_value_w", int'(if_w.value), m_val_w);
      chk("cyc_value_s", int'(if_s.value), m_val_s);
      chk("cyc_dir_w", int'(if_w.dir), int'(m_dir));
      chk("cyc_dir_s", int'(if_s.dir), int'(m_dir));
      chk("cyc_step_w", int'(if_w.step), int'(m_step));
      chk("cyc_step_s", int'(if_s.step), int'(m_step));
      chk("cyc_err_w", int'(if_w.err), int'(m_err));
      chk("cyc_err_s", int'(if_s.err), int'(m_err));
      chk("cyc_sticky_w", int'(if_w.err_sticky), int'(m_sticky));
      chk("cyc_sticky_s", int'(if_s.err_sticky), int'(m_sticky));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: the next posedge is the first sampling edge.
  task automatic set_ab(input logic na, input logic nb, output int due);
    ev_t e;
    tb_a = na;
    tb_b = nb;
    due  = edge_n + 1 + LAT;
    e.due = due;
    e.ab  = {na, nb};
    evq.push_back(e);
  endtask

  task automatic move(input logic [1:0] ab, input int hold);
    int d;
    set_ab(ab[1], ab[0], d);
    tick(hold);
  endtask

  task automatic up_cycles(input int n);
    for (int c = 0; c < n; c++)
      for (int i = 0; i < 4; i++) move(up_seq[i], 8);
  endtask

  task automatic dn_cycles(input int n);
    for (int c = 0; c < n; c++)
      for (int i = 0; i < 4; i++) move(dn_seq[i], 8);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (evq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", evq.size(), 0);
    tick(2);
  endtask

  task automatic pulse_clear();
    tb_clear = 1'b1;
    tick(1);
    tb_clear = 1'b0;
    tick(1);
  endtask

  task automatic pulse_load(input int v);
    tb_load = 1'b1;
    tb_lv   = 8'(v);
    tick(1);
    tb_load = 1'b0;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, sample_edge, due, guard;
    up_seq[0] = 2'b10; up_seq[1] = 2'b11; up_seq[2] = 2'b01; up_seq[3] = 2'b00;
    dn_seq[0] = 2'b01; dn_seq[1] = 2'b11; dn_seq[2] = 2'b10; dn_seq[3] = 2'b00;
    rst_n = 1'b0; tb_a = 1'b0; tb_b = 1'b0; tb_mode = 2'd2;
    tb_clear = 1'b0; tb_load = 1'b0; tb_lv = '0;
    tick(3);
    chk("rst_value", int'(if_w.value), 0);
    chk("rst_dir", int'(if_w.dir), 0);
    chk("rst_step", int'(if_w.step), 0);
    chk("rst_err", int'(if_w.err), 0);
    chk("rst_sticky", int'(if_w.err_sticky), 0);
    rst_n = 1'b1;
    tick(2);

    // x4 up then down
    s0 = step_pulses;
    up_cycles(4);
    drain();
    chk("x4_up_value", int'(if_w.value), 16);
    chk("x4_up_dir", int'(if_w.dir), 1);
    chk("x4_up_steps", step_pulses - s0, 16);
    dn_cycles(2);
    drain();
    chk("x4_dn_value", int'(if_w.value), 8);
    chk("x4_dn_dir", int'(if_w.dir), 0);
    $display("x4: value=%0d dir=%0d", if_w.value, if_w.dir);

    // x1 and x2
    pulse_clear();
    tb_mode = 2'd0;
    s0 = step_pulses;
    up_cycles(4);
    drain();
    chk("x1_value", int'(if_w.value), 4);
    chk("x1_steps", step_pulses - s0, 4);
    pulse_clear();
    tb_mode = 2'd1;
    s0 = step_pulses;
    up_cycles(4);
    drain();
    chk("x2_value", int'(if_w.value), 8);
    chk("x2_steps", step_pulses - s0, 8);
    $display("x1/x2: value=%0d", if_w.value);

    // glitch rejection and latency
    pulse_clear();
    tb_mode = 2'd2;
    s0 = step_pulses;
    tb_a = 1'b1;
    tick(3);
    tb_a = 1'b0;
    tick(14);
    chk("glitch_value", int'(if_w.value), 0);
    chk("glitch_steps", step_pulses - s0, 0);
    sample_edge = edge_n + 1;
    set_ab(1'b1, 1'b0, due);
    drain();
    chk("level_steps", step_pulses - s0, 1);
    chk("level_value", int'(if_w.value), 1);
    chk("level_latency", last_step_edge - sample_edge, 7);
    move(2'b00, 8);
    drain();
    $display("glitch: latency=%0d", last_step_edge - sample_edge);

    // wrap / saturate
    pulse_load(254);
    move(2'b10, 8); move(2'b11, 8); move(2'b01, 8);
    drain();
    chk("wrap_up", int'(if_w.value), 1);
    chk("sat_up", int'(if_s.value), 255);
    pulse_load(1);
    move(2'b11, 8); move(2'b10, 8); move(2'b00, 8);
    drain();
    chk("sat_dn", int'(if_s.value), 0);
    chk("wrap_dn", int'(if_w.value), 254);
    $display("wrap/sat: w=%0d s=%0d", if_w.value, if_s.value);

    // illegal transition
    e0 = err_pulses;
    move(2'b11, 8);
    drain();
    chk("illegal_err_pulses", err_pulses - e0, 1);
    chk("illegal_sticky", int'(if_w.err_sticky), 1);
    chk("illegal_value_w", int'(if_w.value), 254);
    pulse_clear();
    chk("clear_value", int'(if_w.value), 0);
    chk("clear_sticky", int'(if_w.err_sticky), 0);
    move(2'b01, 8); move(2'b00, 8);
    drain();
    chk("post_illegal_value", int'(if_w.value), 2);
    $display("illegal: err_pulses=%0d", err_pulses - e0);

    // load coinciding with a counted step
    set_ab(1'b1, 1'b0, due);
    guard = 0;
    while (edge_n < due - 1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("prio_align", edge_n, due - 1);
    tb_load = 1'b1;
    tb_lv   = 8'd100;
    @(negedge clk);
    tb_load = 1'b0;
    chk("prio_value", int'(if_w.value), 100);
    chk("prio_step", int'(if_w.step), 1);
    chk("prio_dir", int'(if_w.dir), 1);
    tick(2);
    $display("priority: value=%0d", if_w.value);

    // async reset mid-sequence
    move(2'b11, 8);
    drain();
    chk("pre_rst_value", int'(if_w.value), 101);
    set_ab(1'b0, 1'b1, due);
    tick(3);
    #2;
    rst_n = 1'b0;
    tb_a = 1'b0;
    tb_b = 1'b0;
    #1;
    chk("arst_value_w", int'(if_w.value), 0);
    chk("arst_value_s", int'(if_s.value), 0);
    chk("arst_dir", int'(if_w.dir), 0);
    chk("arst_step", int'(if_w.step), 0);
    chk("arst_err", int'(if_w.err), 0);
    chk("arst_sticky", int'(if_w.err_sticky), 0);
    tick(3);
    rst_n = 1'b1;
    tick(12);
    chk("post_rst_value", int'(if_w.value), 0);
    $display("reset: value=%0d", if_w.value);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
